// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: segment count and
// parameter sanity check used at elaboration.
package cla_pkg;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic bit seg_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead segment: bit generate/propagate,
// prefix group terms, and every internal carry derived straight from ci.
module cla_seg #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [SEG_W-1:0] gg;
  logic [SEG_W-1:0] pp;
  logic [SEG_W:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;

  // gg/pp[i] are the group generate/propagate over bits [i:0].
  for (genvar gi = 0; gi < SEG_W; gi++) begin : g_bit
    if (gi == 0) begin : g_first
      assign gg[gi] = g[gi];
      assign pp[gi] = p[gi];
    end else begin : g_rest
      assign gg[gi] = g[gi] | (p[gi] & gg[gi-1]);
      assign pp[gi] = p[gi] & pp[gi-1];
    end
    assign c[gi+1] = gg[gi] | (pp[gi] & ci);
  end

  assign s        = p ^ c[SEG_W-1:0];
  assign co       = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one CLA segment per register stage, carry and
// the unconsumed upper operand slices ride along with each operation.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!seg_ok(WIDTH, SEG_W)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
    localparam int PW  = (gi + 1) * SEG_W;
    localparam int SKW = (NSEG - 1 - gi) * SEG_W;

    // Operand bits not yet added when this stage sees the operation.
    logic [SKW+SEG_W-1:0] a_in;
    logic [SKW+SEG_W-1:0] b_in;
    logic [SEG_W-1:0]     seg_s;
    logic                 seg_ci;
    logic                 seg_co;
    logic                 seg_cmsb;
    logic                 valid_in;
    logic [PW-1:0]        psum_d;
    logic [PW-1:0]        psum_q;
    logic                 valid_q;
    logic                 carry_q;

    if (gi == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign seg_ci   = sub | cin;
      assign valid_in = in_valid;
      assign psum_d   = seg_s;
    end else begin : g_body
      assign a_in     = g_stage[gi-1].g_skew.a_q;
      assign b_in     = g_stage[gi-1].g_skew.b_q;
      assign seg_ci   = g_stage[gi-1].carry_q;
      assign valid_in = g_stage[gi-1].valid_q;
      assign psum_d   = {seg_s, g_stage[gi-1].psum_q};
    end

    cla_seg #(.SEG_W(SEG_W)) u_seg (
      .a        (a_in[SEG_W-1:0]),
      .b        (b_in[SEG_W-1:0]),
      .ci       (seg_ci),
      .s        (seg_s),
      .co       (seg_co),
      .c_msb_in (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        psum_q  <= '0;
      end else if (en) begin
        valid_q <= valid_in;
        carry_q <= seg_co;
        psum_q  <= psum_d;
      end
    end

    if (gi < NSEG - 1) begin : g_skew
      logic [SKW-1:0] a_q;
      logic [SKW-1:0] b_q;
      logic           unused_cmsb;

      assign unused_cmsb = seg_cmsb;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[SKW+SEG_W-1:SEG_W];
          b_q <= b_in[SKW+SEG_W-1:SEG_W];
        end
      end
    end else begin : g_tail
      // Signed overflow: carry into the MSB differs from carry out of it.
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= seg_cmsb ^ seg_co;
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].valid_q;
  assign sum       = g_stage[NSEG-1].psum_q;
  assign cout      = g_stage[NSEG-1].carry_q;
  assign ovf       = g_stage[NSEG-1].g_tail.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: a 32/16 and a 64/8 instance, scoreboard fed on
// accept and drained on output transfer, plus stall/reset sequences.
module tb_cla_pipe_adder;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic clk;
  logic rst;

  logic        x_in_valid, x_in_ready, x_cin, x_sub, x_out_valid, x_out_ready, x_cout, x_ovf;
  logic [31:0] x_a, x_b, x_sum;
  logic        y_in_valid, y_in_ready, y_cin, y_sub, y_out_valid, y_out_ready, y_cout, y_ovf;
  logic [63:0] y_a, y_b, y_sum;

  exp_t x_exp, y_exp;
  exp_t q32[$];
  exp_t q64[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   rand_done;

  vec_t tab32[8];
  vec_t tab64[3];

  cla_pipe_adder #(.WIDTH(32), .SEG_W(16)) u_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub),
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .sum(x_sum), .cout(x_cout), .ovf(x_ovf)
  );

  cla_pipe_adder #(.WIDTH(64), .SEG_W(8)) u_y (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .a(y_a), .b(y_b), .cin(y_cin), .sub(y_sub),
    .out_valid(y_out_valid), .out_ready(y_out_ready),
    .sum(y_sum), .cout(y_cout), .ovf(y_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic cin,
                              input logic sub, input logic [63:0] s, input logic co,
                              input logic ov);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sum = s; v.cout = co; v.ovf = ov;
    return v;
  endfunction

  // Reference: plain wide arithmetic with sign-rule overflow.
  function automatic vec_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [64:0] full;
    logic [63:0] mask, am, bb, s;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
    s    = full[63:0] & mask;
    return mk(am, b & mask, cin, sub, s, full[w], (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q32.delete();
        q64.delete();
      end else begin
        if (x_out_valid && x_out_ready) begin
          if (q32.size() == 0) chk("x_unexpected_output", 64'd1, 64'd0);
          else begin
            e = q32.pop_front();
            $display("x out sum=%h cout=%b ovf=%b (want %h %b %b)", x_sum, x_cout, x_ovf,
                     e.sum[31:0], e.cout, e.ovf);
            chk("x_sum", {32'd0, x_sum}, e.sum);
            chk("x_cout", {63'd0, x_cout}, {63'd0, e.cout});
            chk("x_ovf", {63'd0, x_ovf}, {63'd0, e.ovf});
            if (e.chk_lat) chk("x_latency", 64'(cyc - e.acc_cyc), 64'd2);
          end
        end
        if (x_in_valid && x_in_ready) begin
          e = x_exp; e.acc_cyc = cyc; q32.push_back(e);
        end
        if (y_out_valid && y_out_ready) begin
          if (q64.size() == 0) chk("y_unexpected_output", 64'd1, 64'd0);
          else begin
            e = q64.pop_front();
            $display("y out sum=%h cout=%b ovf=%b (want %h %b %b)", y_sum, y_cout, y_ovf,
                     e.sum, e.cout, e.ovf);
            chk("y_sum", y_sum, e.sum);
            chk("y_cout", {63'd0, y_cout}, {63'd0, e.cout});
            chk("y_ovf", {63'd0, y_ovf}, {63'd0, e.ovf});
            if (e.chk_lat) chk("y_latency", 64'(cyc - e.acc_cyc), 64'd8);
          end
        end
        if (y_in_valid && y_in_ready) begin
          e = y_exp; e.acc_cyc = cyc; q64.push_back(e);
        end
      end
    end
  endtask

  task automatic set_x(input vec_t v, input bit lat);
    x_a = v.a[31:0]; x_b = v.b[31:0]; x_cin = v.cin; x_sub = v.sub; x_in_valid = 1'b1;
    x_exp.sum = v.sum; x_exp.cout = v.cout; x_exp.ovf = v.ovf; x_exp.acc_cyc = 0; x_exp.chk_lat = lat;
  endtask

  task automatic set_y(input vec_t v, input bit lat);
    y_a = v.a; y_b = v.b; y_cin = v.cin; y_sub = v.sub; y_in_valid = 1'b1;
    y_exp.sum = v.sum; y_exp.cout = v.cout; y_exp.ovf = v.ovf; y_exp.acc_cyc = 0; y_exp.chk_lat = lat;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic wait_accept(input bit is_y);
    int n = 0;
    @(negedge clk);
    while (!(is_y ? y_in_ready : x_in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(is_y ? y_in_ready : x_in_ready)) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    x_in_valid = 1'b0;
    y_in_valid = 1'b0;
    while ((q32.size() != 0 || q64.size() != 0 || x_out_valid || y_out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    x_in_valid = 0; x_a = 0; x_b = 0; x_cin = 0; x_sub = 0; x_out_ready = 1;
    y_in_valid = 0; y_a = 0; y_b = 0; y_cin = 0; y_sub = 0; y_out_ready = 1;
    x_exp = '{default: 0};
    y_exp = '{default: 0};
    rand_done = 0;

    tab32[0] = mk(64'hFFFFFFFF, 64'h00000001, 0, 0, 64'h00000000, 1, 0);
    tab32[1] = mk(64'h7FFFFFFF, 64'h00000001, 0, 0, 64'h80000000, 0, 1);
    tab32[2] = mk(64'h00000005, 64'h00000007, 0, 1, 64'hFFFFFFFE, 0, 0);
    tab32[3] = mk(64'h00000007, 64'h00000005, 1, 1, 64'h00000002, 1, 0);
    tab32[4] = mk(64'h00000000, 64'h00000000, 1, 0, 64'h00000001, 0, 0);
    tab32[5] = mk(64'h80000000, 64'h80000000, 0, 0, 64'h00000000, 1, 1);
    tab32[6] = mk(64'h80000000, 64'h00000001, 0, 1, 64'h7FFFFFFF, 1, 1);
    tab32[7] = mk(64'h0000FFFF, 64'h00000001, 0, 0, 64'h00010000, 0, 0);
    tab64[0] = mk(64'h00FF00FF00FF00FF, 64'h0001000100010001, 0, 0, 64'h0100010001000100, 0, 0);
    tab64[1] = mk(64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 0, 0, 64'h0000000000000000, 1, 0);
    tab64[2] = mk(64'h0000000000000000, 64'h0000000000000001, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 0);

    fork
      monitor();
      forever begin @(posedge clk); cyc++; end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_x_out_valid", {63'd0, x_out_valid}, 64'd0);
    chk("reset_x_sum", {32'd0, x_sum}, 64'd0);
    chk("reset_x_flags", {62'd0, x_cout, x_ovf}, 64'd0);
    chk("reset_y_out_valid", {63'd0, y_out_valid}, 64'd0);
    chk("reset_y_sum", y_sum, 64'd0);
    chk("reset_x_in_ready", {63'd0, x_in_ready}, 64'd1);

    // Table streamed back-to-back at full rate, latency checked per result.
    for (int i = 0; i < 8; i++) begin
      set_x(tab32[i], 1'b1);
      wait_accept(1'b0);
    end
    drain();

    // Backpressure with the pipe full.
    set_x(mk(1, 2, 0, 0, 3, 0, 0), 1'b0);              wait_accept(1'b0);
    set_x(mk(10, 20, 0, 0, 30, 0, 0), 1'b0);           wait_accept(1'b0);
    x_out_ready = 1'b0;
    set_x(mk(64'h100, 64'h200, 0, 0, 64'h300, 0, 0), 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, x_in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, x_out_valid}, 64'd1);
      chk("stall_sum_hold", {30'd0, x_cout, x_ovf, x_sum}, 64'd3);
      @(posedge clk); #1;
    end
    x_out_ready = 1'b1;
    wait_accept(1'b0);
    drain();

    // Reset with two operations in flight.
    set_x(mk(64'hFFFFFFFF, 64'hFFFFFFFF, 0, 0, 64'hFFFFFFFE, 1, 0), 1'b0); wait_accept(1'b0);
    set_x(mk(64'h12345678, 64'h11111111, 0, 0, 64'h23456789, 0, 0), 1'b0); wait_accept(1'b0);
    x_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {63'd0, x_out_valid}, 64'd0);
    chk("midrst_sum", {30'd0, x_cout, x_ovf, x_sum}, 64'd0);
    chk("midrst_in_ready", {63'd0, x_in_ready}, 64'd1);
    repeat (5) @(posedge clk);
    #1 chk("midrst_no_stale", {63'd0, x_out_valid}, 64'd0);

    // Wide instance: directed table, then random ops under random backpressure.
    for (int i = 0; i < 3; i++) begin
      set_y(tab64[i], 1'b1);
      wait_accept(1'b1);
    end
    drain();

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [63:0] ra, rb;
          ra = {$urandom, $urandom};
          rb = (i % 8 == 0) ? ~ra : {$urandom, $urandom};
          set_y(model(64, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), 1'b0);
          wait_accept(1'b1);
        end
        y_in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          y_out_ready = 1'($urandom_range(0, 1));
        end
        y_out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
